// File: rtl/xadc_drp_pkg.sv
// -----------------------------------------------------------------------------
// xadc_drp_pkg
// Shared definitions for the XADC DRP responder model:
//   - default timing parameters (conversion length, DRP read latency)
//   - DRP register address constants and the aux result page
//   - reset value of the aux sequence mask, fixed temperature reading
//   - sequencer state encoding and a small address-decode helper
// -----------------------------------------------------------------------------
package xadc_drp_pkg;

    localparam int DEF_CONV_CYCLES = 26;
    localparam int DEF_DRP_LAT     = 2;

    localparam logic [6:0] ADDR_TEMP     = 7'h00;
    localparam logic [6:0] ADDR_CFG0     = 7'h40;
    localparam logic [6:0] ADDR_CFG1     = 7'h41;
    localparam logic [6:0] ADDR_CFG2     = 7'h42;
    localparam logic [6:0] ADDR_SEQ_CFG  = 7'h48;
    localparam logic [6:0] ADDR_SEQ_MASK = 7'h49;

    // Aux results occupy 0x10-0x1F: upper address bits select the page.
    localparam logic [2:0] AUX_PAGE = 3'b001;

    localparam logic [15:0] SEQ_MASK_RST = 16'hC0C0;
    localparam logic [15:0] TEMP_VALUE   = 16'h9B30;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,   // out of reset, conversion not yet started
        SEQ_BUSY = 2'd1,   // conversion in progress (busy_out=1)
        SEQ_EOC  = 2'd2    // end-of-conversion cycle (eoc_out=1)
    } seq_state_t;

    function automatic logic is_aux_addr(input logic [6:0] addr);
        return addr[6:4] == AUX_PAGE;
    endfunction

endpackage

// File: rtl/xadc_seq_next.sv
// -----------------------------------------------------------------------------
// xadc_seq_next
// Combinational next-enabled-channel finder for the aux sequencer.
// Ports:
//   mask     in  16  channel enable mask, bit i enables aux channel i
//   cur_idx  in  4   index of the channel currently being converted
//   next_idx out 4   lowest enabled index above cur_idx, else lowest enabled
//   wrap     out 1   no enabled index above cur_idx (cur_idx is the last one
//                    of the sequence); also 1 when the mask is empty
// -----------------------------------------------------------------------------
module xadc_seq_next
    import xadc_drp_pkg::*;
(
    input  logic [15:0] mask,
    input  logic [3:0]  cur_idx,
    output logic [3:0]  next_idx,
    output logic        wrap
);

    logic       found_hi;
    logic [3:0] hi_idx;
    logic [3:0] lo_idx;

    // Scanning downwards leaves the lowest matching index in each variable.
    always_comb begin
        found_hi = 1'b0;
        hi_idx   = 4'd0;
        lo_idx   = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) begin
                lo_idx = 4'(i);
                if (4'(i) > cur_idx) begin
                    hi_idx   = 4'(i);
                    found_hi = 1'b1;
                end
            end
        end
        next_idx = found_hi ? hi_idx : lo_idx;
        wrap     = !found_hi;
    end

endmodule

// File: rtl/xadc_drp_responder.sv
// -----------------------------------------------------------------------------
// xadc_drp_responder
// Behavioural stand-in for an XADC: a DRP register slave plus a continuous
// aux-channel conversion sequencer producing deterministic ramp results.
// Ports:
//   clk          in  1   single clock, rising edge
//   rst_n        in  1   asynchronous active-low reset
//   daddr_in     in  7   DRP address
//   den_in       in  1   DRP request strobe
//   dwe_in       in  1   DRP write enable (sampled with den_in)
//   di_in        in  16  DRP write data
//   do_out       out 16  DRP read data, non-zero only while drdy_out=1
//   drdy_out     out 1   completion pulse, DRP_LAT cycles after acceptance
//   busy_out     out 1   conversion in progress
//   eoc_out      out 1   end-of-conversion pulse
//   channel_out  out 5   channel of the last completed conversion
//   eos_out      out 1   end-of-sequence pulse (with eoc of last channel)
//   drp_err      out 1   sticky: request arrived while one was outstanding
// Handshake: a request is accepted on a rising edge with den_in=1 and nothing
// outstanding; exactly one drdy_out pulse follows DRP_LAT edges later and the
// next request may be presented in the drdy_out cycle. Requests arriving while
// one is outstanding are dropped and flagged on drp_err.
// -----------------------------------------------------------------------------
module xadc_drp_responder
    import xadc_drp_pkg::*;
#(
    parameter int CONV_CYCLES = DEF_CONV_CYCLES,
    parameter int DRP_LAT     = DEF_DRP_LAT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  daddr_in,
    input  logic        den_in,
    input  logic        dwe_in,
    input  logic [15:0] di_in,
    output logic [15:0] do_out,
    output logic        drdy_out,
    output logic        busy_out,
    output logic        eoc_out,
    output logic [4:0]  channel_out,
    output logic        eos_out,
    output logic        drp_err
);

    localparam int CCW = $clog2(CONV_CYCLES + 1);
    localparam int LCW = $clog2(DRP_LAT + 1);

    // ---------------- register file ----------------
    logic [15:0] cfg0, cfg1, cfg2, seq_cfg, seq_mask;

    // Ramp values; the visible result register is always {v, 4'h0}.
    logic [11:0] ramp [16];

    // ---------------- DRP request tracking ----------------
    logic           pend;
    logic [LCW-1:0] lat_cnt;
    logic [15:0]    rdata;
    logic [15:0]    rd_val;

    // ---------------- sequencer ----------------
    seq_state_t     seq_state;
    logic [CCW-1:0] conv_cnt;
    logic [3:0]     cur_idx;
    logic           cur_temp;   // empty mask: converting the temperature channel
    logic [3:0]     nxt_idx;
    logic           nxt_wrap;

    xadc_seq_next u_seq_next (
        .mask     (seq_mask),
        .cur_idx  (cur_idx),
        .next_idx (nxt_idx),
        .wrap     (nxt_wrap)
    );

    // Read mux; sampled on the accepting edge so same-edge updates are not seen.
    always_comb begin
        rd_val = 16'h0000;
        if (daddr_in == ADDR_TEMP) begin
            rd_val = TEMP_VALUE;
        end else if (is_aux_addr(daddr_in)) begin
            rd_val = {ramp[daddr_in[3:0]], 4'h0};
        end else begin
            case (daddr_in)
                ADDR_CFG0:     rd_val = cfg0;
                ADDR_CFG1:     rd_val = cfg1;
                ADDR_CFG2:     rd_val = cfg2;
                ADDR_SEQ_CFG:  rd_val = seq_cfg;
                ADDR_SEQ_MASK: rd_val = seq_mask;
                default:       rd_val = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= 1'b0;
            lat_cnt  <= '0;
            rdata    <= 16'h0000;
            do_out   <= 16'h0000;
            drdy_out <= 1'b0;
            drp_err  <= 1'b0;
            cfg0     <= 16'h0000;
            cfg1     <= 16'h0000;
            cfg2     <= 16'h0000;
            seq_cfg  <= 16'h0000;
            seq_mask <= SEQ_MASK_RST;
        end else begin
            drdy_out <= 1'b0;
            do_out   <= 16'h0000;
            if (pend) begin
                if (lat_cnt == LCW'(DRP_LAT)) begin
                    pend     <= 1'b0;
                    drdy_out <= 1'b1;
                    do_out   <= rdata;
                end else begin
                    lat_cnt <= lat_cnt + LCW'(1);
                end
                if (den_in) begin
                    drp_err <= 1'b1;
                end
            end else if (den_in) begin
                pend    <= 1'b1;
                lat_cnt <= LCW'(1);
                rdata   <= dwe_in ? 16'h0000 : rd_val;
                if (dwe_in) begin
                    case (daddr_in)
                        ADDR_CFG0:     cfg0     <= di_in;
                        ADDR_CFG1:     cfg1     <= di_in;
                        ADDR_CFG2:     cfg2     <= di_in;
                        ADDR_SEQ_CFG:  seq_cfg  <= di_in;
                        ADDR_SEQ_MASK: seq_mask <= di_in;
                        default: ;  // read-only or unmapped: discarded
                    endcase
                end
            end
        end
    end

    // Sequencer: CONV_CYCLES busy cycles, then one eoc cycle, repeating.
    // The next channel is picked on the edge leaving IDLE/EOC, so a mask
    // write lands at the next selection and never disturbs a running one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_state   <= SEQ_IDLE;
            conv_cnt    <= '0;
            busy_out    <= 1'b0;
            eoc_out     <= 1'b0;
            eos_out     <= 1'b0;
            channel_out <= 5'h00;
            cur_idx     <= 4'd15;   // makes the first pick the lowest enabled
            cur_temp    <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                ramp[i] <= 12'h000;
            end
        end else begin
            case (seq_state)
                SEQ_IDLE, SEQ_EOC: begin
                    seq_state <= SEQ_BUSY;
                    busy_out  <= 1'b1;
                    eoc_out   <= 1'b0;
                    eos_out   <= 1'b0;
                    conv_cnt  <= CCW'(1);
                    cur_temp  <= (seq_mask == 16'h0000);
                    cur_idx   <= (seq_mask == 16'h0000) ? 4'd15 : nxt_idx;
                end
                SEQ_BUSY: begin
                    if (conv_cnt == CCW'(CONV_CYCLES)) begin
                        seq_state <= SEQ_EOC;
                        busy_out  <= 1'b0;
                        eoc_out   <= 1'b1;
                        if (cur_temp) begin
                            channel_out <= 5'h00;
                            eos_out     <= 1'b1;
                        end else begin
                            channel_out   <= {1'b1, cur_idx};
                            eos_out       <= nxt_wrap;
                            ramp[cur_idx] <= ramp[cur_idx] + 12'(cur_idx) + 12'd1;
                        end
                    end else begin
                        conv_cnt <= conv_cnt + CCW'(1);
                    end
                end
                default: begin
                    seq_state <= SEQ_IDLE;
                    busy_out  <= 1'b0;
                    eoc_out   <= 1'b0;
                    eos_out   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xadc_drp_responder.sv
// -----------------------------------------------------------------------------
// tb_xadc_drp_responder
// Directed bench for xadc_drp_responder at default parameters
// (CONV_CYCLES=26, DRP_LAT=2). Inputs change and outputs are sampled on the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_xadc_drp_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  daddr = 7'h00;
    logic        den = 1'b0;
    logic        dwe = 1'b0;
    logic [15:0] di = 16'h0000;
    logic [15:0] do_out;
    logic        drdy_out;
    logic        busy_out;
    logic        eoc_out;
    logic [4:0]  channel_out;
    logic        eos_out;
    logic        drp_err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    xadc_drp_responder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .daddr_in    (daddr),
        .den_in      (den),
        .dwe_in      (dwe),
        .di_in       (di),
        .do_out      (do_out),
        .drdy_out    (drdy_out),
        .busy_out    (busy_out),
        .eoc_out     (eoc_out),
        .channel_out (channel_out),
        .eos_out     (eos_out),
        .drp_err     (drp_err)
    );

    // ---------------- driver tasks ----------------
    // Returns on the falling edge just before the first post-reset rising edge.
    task automatic apply_reset();
        rst_n = 1'b0;
        den   = 1'b0;
        dwe   = 1'b0;
        daddr = 7'h00;
        di    = 16'h0000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Waits (bounded) until eoc_out is seen; cycles = falling edges waited.
    task automatic wait_eoc(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (eoc_out !== 1'b1 && cycles < 60);
        vectors++;
        if (eoc_out !== 1'b1) begin
            miscompares++;
            $display("FAIL eoc_timeout: eoc_out=%b after %0d cycles, expected 1", eoc_out, cycles);
        end
    endtask

    // One DRP transaction; checks drdy latency and that do_out idles at 0.
    task automatic drp_access(input logic [6:0] addr, input logic we,
                              input logic [15:0] data, output logic [15:0] rdata);
        int lat;
        daddr = addr;
        dwe   = we;
        di    = data;
        den   = 1'b1;
        @(negedge clk);
        den = 1'b0;
        dwe = 1'b0;
        lat = 1;
        while (drdy_out !== 1'b1 && lat < 12) begin
            vectors++;
            if (do_out !== 16'h0000) begin
                miscompares++;
                $display("FAIL do_idle: addr=%h do_out=%h without drdy, expected 0000", addr, do_out);
            end
            @(negedge clk);
            lat++;
        end
        rdata = do_out;
        vectors++;
        if (lat != 3) begin
            miscompares++;
            $display("FAIL drdy_latency: addr=%h latency=%0d, expected 3", addr, lat);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({do_out, drdy_out, busy_out, eoc_out, eos_out, drp_err} !== 21'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: do=%h drdy=%b busy=%b eoc=%b eos=%b err=%b, expected all 0",
                     do_out, drdy_out, busy_out, eoc_out, eos_out, drp_err);
        end
        vectors++;
        if (channel_out !== 5'h00) begin
            miscompares++;
            $display("FAIL reset_channel: got %h expected 00", channel_out);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy_out !== 1'b1) begin
            miscompares++;
            $display("FAIL first_busy: busy_out=%b after first edge, expected 1", busy_out);
        end
    endtask

    task automatic test_first_conversion();
        int c;
        logic [15:0] rd;
        logic [6:0]  ra [7]  = '{7'h16, 7'h00, 7'h05, 7'h25, 7'h49, 7'h40, 7'h4F};
        logic [15:0] re [7]  = '{16'h0070, 16'h9B30, 16'h0000, 16'h0000, 16'hC0C0, 16'h0000, 16'h0000};
        apply_reset();
        wait_eoc(c);
        vectors++;
        if (c != 27) begin
            miscompares++;
            $display("FAIL first_eoc_cycle: eoc at cycle %0d, expected 27", c);
        end
        vectors++;
        if ({channel_out, eos_out, busy_out} !== {5'h16, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL first_eoc_state: ch=%h eos=%b busy=%b, expected ch=16 eos=0 busy=0",
                     channel_out, eos_out, busy_out);
        end
        for (int i = 0; i < 7; i++) begin
            drp_access(ra[i], 1'b0, 16'h0000, rd);
            vectors++;
            if (rd !== re[i]) begin
                miscompares++;
                $display("FAIL read_map: addr=%h got %h expected %h", ra[i], rd, re[i]);
            end
        end
    endtask

    task automatic test_sequence();
        int c;
        logic [15:0] rd;
        logic [4:0]  ech  [4] = '{5'h16, 5'h17, 5'h1E, 5'h1F};
        logic        eeos [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [6:0]  ra   [3] = '{7'h17, 7'h1E, 7'h1F};
        logic [15:0] re   [3] = '{16'h0080, 16'h00F0, 16'h0100};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            wait_eoc(c);
            vectors++;
            if (channel_out !== ech[i] || eos_out !== eeos[i]) begin
                miscompares++;
                $display("FAIL seq_order: conv %0d ch=%h eos=%b, expected ch=%h eos=%b",
                         i, channel_out, eos_out, ech[i], eeos[i]);
            end
            if (i > 0) begin
                vectors++;
                if (c != 27) begin
                    miscompares++;
                    $display("FAIL seq_period: conv %0d period %0d, expected 27", i, c);
                end
            end
        end
        @(negedge clk);
        vectors++;
        if ({eoc_out, eos_out, busy_out} !== 3'b001) begin
            miscompares++;
            $display("FAIL eoc_pulse_width: eoc=%b eos=%b busy=%b, expected 0 0 1", eoc_out, eos_out, busy_out);
        end
        for (int i = 0; i < 3; i++) begin
            drp_access(ra[i], 1'b0, 16'h0000, rd);
            vectors++;
            if (rd !== re[i]) begin
                miscompares++;
                $display("FAIL seq_result: addr=%h got %h expected %h", ra[i], rd, re[i]);
            end
        end
    endtask

    task automatic test_mask_change();
        int c;
        logic [15:0] rd;
        apply_reset();
        repeat (10) @(negedge clk);
        drp_access(7'h49, 1'b1, 16'h0001, rd);
        wait_eoc(c);
        vectors++;
        if (channel_out !== 5'h16) begin
            miscompares++;
            $display("FAIL mask_current_completes: ch=%h expected 16", channel_out);
        end
        for (int i = 1; i <= 3; i++) begin
            wait_eoc(c);
            vectors++;
            if (channel_out !== 5'h10 || eos_out !== 1'b1) begin
                miscompares++;
                $display("FAIL mask_single_channel: conv %0d ch=%h eos=%b, expected ch=10 eos=1",
                         i, channel_out, eos_out);
            end
            if (i < 3) begin
                drp_access(7'h10, 1'b0, 16'h0000, rd);
                vectors++;
                if (rd !== 16'(i * 16)) begin
                    miscompares++;
                    $display("FAIL mask_ramp: conv %0d read 10 got %h expected %h", i, rd, 16'(i * 16));
                end
            end else begin
                drp_access(7'h49, 1'b1, 16'h0000, rd);
            end
        end
        // Conversion running during the empty-mask write is 0x10; the one after is temperature.
        wait_eoc(c);
        vectors++;
        if (channel_out !== 5'h10) begin
            miscompares++;
            $display("FAIL mask_zero_pending: ch=%h expected 10", channel_out);
        end
        wait_eoc(c);
        vectors++;
        if (channel_out !== 5'h00 || eos_out !== 1'b1) begin
            miscompares++;
            $display("FAIL mask_zero_temp: ch=%h eos=%b, expected ch=00 eos=1", channel_out, eos_out);
        end
        drp_access(7'h10, 1'b0, 16'h0000, rd);
        vectors++;
        if (rd !== 16'h0040) begin
            miscompares++;
            $display("FAIL mask_zero_result: read 10 got %h expected 0040", rd);
        end
    endtask

    task automatic test_drp_error();
        int drdy_cnt;
        logic [15:0] first_data;
        logic [15:0] rd;
        apply_reset();
        @(negedge clk);
        vectors++;
        if (drp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_initial: drp_err=%b expected 0", drp_err);
        end
        drdy_cnt   = 0;
        first_data = 16'h0000;
        daddr = 7'h00; dwe = 1'b0; den = 1'b1;
        @(negedge clk);
        if (drdy_out === 1'b1) drdy_cnt++;
        daddr = 7'h41; dwe = 1'b1; di = 16'h1234; den = 1'b1;
        @(negedge clk);
        if (drdy_out === 1'b1) drdy_cnt++;
        den = 1'b0; dwe = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (drdy_out === 1'b1) begin
                drdy_cnt++;
                first_data = do_out;
            end
        end
        vectors++;
        if (drdy_cnt != 1) begin
            miscompares++;
            $display("FAIL err_drdy_count: %0d drdy pulses, expected 1", drdy_cnt);
        end
        vectors++;
        if (first_data !== 16'h9B30) begin
            miscompares++;
            $display("FAIL err_first_data: got %h expected 9b30", first_data);
        end
        vectors++;
        if (drp_err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_set: drp_err=%b expected 1", drp_err);
        end
        drp_access(7'h41, 1'b0, 16'h0000, rd);
        vectors++;
        if (rd !== 16'h0000) begin
            miscompares++;
            $display("FAIL err_write_dropped: read 41 got %h expected 0000", rd);
        end
        vectors++;
        if (drp_err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_sticky: drp_err=%b expected 1", drp_err);
        end
    endtask

    task automatic test_config_rw();
        logic [15:0] rd;
        logic [6:0]  wa [10] = '{7'h41, 7'h40, 7'h42, 7'h48, 7'h43, 7'h7F, 7'h10, 7'h00, 7'h20, 7'h49};
        logic [15:0] wd [10] = '{16'hA5A5, 16'h1111, 16'h2222, 16'h4848, 16'hFFFF,
                                 16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h1234};
        logic [15:0] re [10] = '{16'hA5A5, 16'h1111, 16'h2222, 16'h4848, 16'h0000,
                                 16'h0000, 16'h0000, 16'h9B30, 16'h0000, 16'h1234};
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            drp_access(wa[i], 1'b1, wd[i], rd);
        end
        for (int i = 0; i < 10; i++) begin
            drp_access(wa[i], 1'b0, 16'h0000, rd);
            vectors++;
            if (rd !== re[i]) begin
                miscompares++;
                $display("FAIL cfg_readback: addr=%h got %h expected %h", wa[i], rd, re[i]);
            end
        end
    endtask

    task automatic test_wrap();
        int c;
        int n;
        logic [15:0] rd;
        apply_reset();
        drp_access(7'h49, 1'b1, 16'h8000, rd);
        n = 0;
        for (int it = 0; it < 300 && n < 256; it++) begin
            wait_eoc(c);
            if (channel_out === 5'h1F) begin
                n++;
                if (n == 255) begin
                    drp_access(7'h1F, 1'b0, 16'h0000, rd);
                    vectors++;
                    if (rd !== 16'hFF00) begin
                        miscompares++;
                        $display("FAIL wrap_255: read 1f got %h expected ff00", rd);
                    end
                end
            end
        end
        vectors++;
        if (n != 256) begin
            miscompares++;
            $display("FAIL wrap_count: %0d conversions of 1f, expected 256", n);
        end
        drp_access(7'h1F, 1'b0, 16'h0000, rd);
        vectors++;
        if (rd !== 16'h0000) begin
            miscompares++;
            $display("FAIL wrap_256: read 1f got %h expected 0000", rd);
        end
    endtask

    task automatic test_reset_mid_request();
        int drdy_cnt;
        daddr = 7'h00; dwe = 1'b0; den = 1'b1;
        @(negedge clk);
        den = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({do_out, drdy_out, busy_out, eoc_out, eos_out, drp_err, channel_out} !== 26'h0) begin
            miscompares++;
            $display("FAIL async_reset: do=%h drdy=%b busy=%b eoc=%b eos=%b err=%b ch=%h, expected all 0",
                     do_out, drdy_out, busy_out, eoc_out, eos_out, drp_err, channel_out);
        end
        drdy_cnt = 0;
        repeat (2) begin
            @(negedge clk);
            if (drdy_out === 1'b1) drdy_cnt++;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (drdy_out === 1'b1) drdy_cnt++;
        end
        vectors++;
        if (drdy_cnt != 0) begin
            miscompares++;
            $display("FAIL dropped_request: %0d drdy pulses, expected 0", drdy_cnt);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_first_conversion();
        test_sequence();
        test_mask_change();
        test_drp_error();
        test_config_rw();
        test_wrap();
        test_reset_mid_request();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
